// File: rtl/rc_packet_ctrl.sv
// rc_packet_ctrl: receive-side USB packet sequencer.
// Arms the line receiver, assembles unstuffed bits into bytes, checks the PID and the data CRC16.
module rc_packet_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_BYTES      = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_hshake,
    input  logic       start_data,
    output logic       receive_hshake,
    output logic       receive_data,
    output logic       abort,
    input  logic       got_sync,
    input  logic       eop_error,
    input  logic       bit_valid,
    input  logic       bit_in,
    input  logic       eop,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic [3:0] pid,
    output logic [6:0] data_len,
    output logic       done,
    output logic [2:0] status
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] ST_ACK       = 3'd0;
    localparam logic [2:0] ST_NAK       = 3'd1;
    localparam logic [2:0] ST_STALL     = 3'd2;
    localparam logic [2:0] ST_DATA_OK   = 3'd3;
    localparam logic [2:0] ST_TIMEOUT   = 3'd4;
    localparam logic [2:0] ST_PID_ERR   = 3'd5;
    localparam logic [2:0] ST_CRC_ERR   = 3'd6;
    localparam logic [2:0] ST_FRAME_ERR = 3'd7;

    localparam logic [15:0] CRC_RESIDUAL = 16'h800D;

    typedef enum logic [2:0] {IDLE, WAIT_SYNC, RX_PID, RX_HS, RX_DATA, FINISH} state_t;

    state_t        state_r;
    logic [TW-1:0] tmo_r;
    logic [7:0]    sr_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    hold0_r;
    logic [7:0]    hold1_r;
    logic [1:0]    hold_cnt_r;
    logic [15:0]   crc_r;
    logic          data_mode_r;

    logic          bit_take_s;
    logic [7:0]    sr_nx_s;
    logic [2:0]    cnt_nx_s;
    logic [15:0]   crc_nx_s;
    logic          byte_done_s;
    logic          emit_s;
    logic          overflow_s;
    logic [1:0]    hold_cnt_nx_s;
    logic          fin_s;
    logic [2:0]    fin_code_s;
    logic          fin_abort_s;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        crc16_step = {crc[14:0], 1'b0} ^ (((crc[15] ^ b) == 1'b1) ? 16'h8005 : 16'h0000);
    endfunction

    function automatic logic pid_accept(input logic [7:0] p, input logic dm);
        logic nib_ok;
        if (dm) begin
            nib_ok = (p[3:0] == 4'b0011) || (p[3:0] == 4'b1011);
        end else begin
            nib_ok = (p[3:0] == 4'b0010) || (p[3:0] == 4'b1010) || (p[3:0] == 4'b1110);
        end
        pid_accept = nib_ok && (p[7:4] == ~p[3:0]);
    endfunction

    function automatic logic [2:0] hs_code(input logic [3:0] p);
        case (p)
            4'b0010: hs_code = ST_ACK;
            4'b1010: hs_code = ST_NAK;
            4'b1110: hs_code = ST_STALL;
            default: hs_code = ST_PID_ERR;
        endcase
    endfunction

    // Next-bit datapath; eop_error suppresses bit processing in the same cycle
    always_comb begin
        bit_take_s = bit_valid && !eop_error;
        if (bit_take_s) begin
            sr_nx_s  = {bit_in, sr_r[7:1]};
            cnt_nx_s = bit_cnt_r + 3'd1;
            crc_nx_s = crc16_step(crc_r, bit_in);
        end else begin
            sr_nx_s  = sr_r;
            cnt_nx_s = bit_cnt_r;
            crc_nx_s = crc_r;
        end
        byte_done_s = bit_take_s && (bit_cnt_r == 3'd7);
        emit_s      = byte_done_s && (hold_cnt_r == 2'd2);
        overflow_s  = emit_s && (data_len == 7'(MAX_BYTES));
        if (byte_done_s && (hold_cnt_r != 2'd2)) begin
            hold_cnt_nx_s = hold_cnt_r + 2'd1;
        end else begin
            hold_cnt_nx_s = hold_cnt_r;
        end
    end

    // Decides whether this cycle ends the packet, and with which result
    always_comb begin
        fin_s       = 1'b0;
        fin_code_s  = ST_ACK;
        fin_abort_s = 1'b0;
        case (state_r)
            WAIT_SYNC: begin
                if (eop_error) begin
                    fin_s = 1'b1; fin_code_s = ST_FRAME_ERR; fin_abort_s = 1'b1;
                end else if (!got_sync && (tmo_r == TW'(TIMEOUT_CYCLES - 1))) begin
                    fin_s = 1'b1; fin_code_s = ST_TIMEOUT; fin_abort_s = 1'b1;
                end else begin
                    fin_s = 1'b0;
                end
            end
            RX_PID: begin
                if (eop_error || eop) begin
                    fin_s = 1'b1; fin_code_s = ST_FRAME_ERR; fin_abort_s = 1'b1;
                end else if (byte_done_s && !pid_accept(sr_nx_s, data_mode_r)) begin
                    fin_s = 1'b1; fin_code_s = ST_PID_ERR; fin_abort_s = 1'b1;
                end else begin
                    fin_s = 1'b0;
                end
            end
            RX_HS: begin
                if (eop_error || bit_valid) begin
                    fin_s = 1'b1; fin_code_s = ST_FRAME_ERR; fin_abort_s = 1'b1;
                end else if (eop) begin
                    fin_s = 1'b1; fin_code_s = hs_code(pid);
                end else begin
                    fin_s = 1'b0;
                end
            end
            RX_DATA: begin
                if (eop_error || overflow_s) begin
                    fin_s = 1'b1; fin_code_s = ST_FRAME_ERR; fin_abort_s = 1'b1;
                end else if (eop) begin
                    fin_s = 1'b1;
                    if ((cnt_nx_s != 3'd0) || (hold_cnt_nx_s != 2'd2)) begin
                        fin_code_s = ST_FRAME_ERR;
                    end else if (crc_nx_s != CRC_RESIDUAL) begin
                        fin_code_s = ST_CRC_ERR;
                    end else begin
                        fin_code_s = ST_DATA_OK;
                    end
                end else begin
                    fin_s = 1'b0;
                end
            end
            default: fin_s = 1'b0;
        endcase
    end

    // Sequencer state, datapath registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            tmo_r          <= '0;
            sr_r           <= 8'd0;
            bit_cnt_r      <= 3'd0;
            hold0_r        <= 8'd0;
            hold1_r        <= 8'd0;
            hold_cnt_r     <= 2'd0;
            crc_r          <= 16'd0;
            data_mode_r    <= 1'b0;
            receive_hshake <= 1'b0;
            receive_data   <= 1'b0;
            abort          <= 1'b0;
            byte_out       <= 8'd0;
            byte_valid     <= 1'b0;
            pid            <= 4'd0;
            data_len       <= 7'd0;
            done           <= 1'b0;
            status         <= 3'd0;
        end else begin
            done       <= 1'b0;
            abort      <= 1'b0;
            byte_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_data || start_hshake) begin
                        data_mode_r    <= start_data;
                        receive_data   <= start_data;
                        receive_hshake <= ~start_data;
                        pid            <= 4'd0;
                        data_len       <= 7'd0;
                        status         <= 3'd0;
                        tmo_r          <= '0;
                        sr_r           <= 8'd0;
                        bit_cnt_r      <= 3'd0;
                        hold0_r        <= 8'd0;
                        hold1_r        <= 8'd0;
                        hold_cnt_r     <= 2'd0;
                        crc_r          <= 16'hFFFF;
                        state_r        <= WAIT_SYNC;
                    end
                end
                WAIT_SYNC: begin
                    tmo_r <= tmo_r + TW'(1);
                    if (got_sync) begin
                        state_r <= RX_PID;
                    end
                end
                RX_PID: begin
                    sr_r      <= sr_nx_s;
                    bit_cnt_r <= cnt_nx_s;
                    if (byte_done_s) begin
                        pid     <= sr_nx_s[3:0];
                        state_r <= data_mode_r ? RX_DATA : RX_HS;
                    end
                end
                RX_HS: state_r <= RX_HS;
                RX_DATA: begin
                    sr_r       <= sr_nx_s;
                    bit_cnt_r  <= cnt_nx_s;
                    crc_r      <= crc_nx_s;
                    hold_cnt_r <= hold_cnt_nx_s;
                    // The two most recent bytes stay held back: at EOP they are the CRC
                    if (byte_done_s) begin
                        if (hold_cnt_r == 2'd0) begin
                            hold0_r <= sr_nx_s;
                        end else if (hold_cnt_r == 2'd1) begin
                            hold1_r <= sr_nx_s;
                        end else if (!overflow_s) begin
                            byte_out   <= hold0_r;
                            byte_valid <= 1'b1;
                            data_len   <= data_len + 7'd1;
                            hold0_r    <= hold1_r;
                            hold1_r    <= sr_nx_s;
                        end
                    end
                end
                FINISH:  state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
            if (fin_s) begin
                state_r        <= FINISH;
                status         <= fin_code_s;
                abort          <= fin_abort_s;
                done           <= 1'b1;
                receive_hshake <= 1'b0;
                receive_data   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rc_packet_ctrl.sv
// tb_rc_packet_ctrl: directed and randomized packets against a packet-level reference model.
module tb_rc_packet_ctrl;
    localparam int TMO  = 16;
    localparam int MAXB = 8;

    logic       clk = 1'b0;
    logic       rst, start_hshake, start_data, got_sync, eop_error, bit_valid, bit_in, eop;
    logic       receive_hshake, receive_data, abort, byte_valid, done;
    logic [7:0] byte_out;
    logic [3:0] pid;
    logic [6:0] data_len;
    logic [2:0] status;

    rc_packet_ctrl #(.TIMEOUT_CYCLES(TMO), .MAX_BYTES(MAXB)) dut (
        .clk(clk), .rst(rst), .start_hshake(start_hshake), .start_data(start_data),
        .receive_hshake(receive_hshake), .receive_data(receive_data), .abort(abort),
        .got_sync(got_sync), .eop_error(eop_error), .bit_valid(bit_valid), .bit_in(bit_in),
        .eop(eop), .byte_out(byte_out), .byte_valid(byte_valid), .pid(pid),
        .data_len(data_len), .done(done), .status(status)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    bit         tx_bits[$];
    logic [7:0] rx_bytes[$];
    logic [7:0] exp_bytes[$];
    int         done_cnt = 0;
    logic [2:0] done_status;
    logic       done_abort;
    logic [1:0] done_rx;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor sampled on the falling edge
    always @(negedge clk) begin
        if (byte_valid === 1'b1) rx_bytes.push_back(byte_out);
        if (done === 1'b1) begin
            done_cnt++;
            done_status = status;
            done_abort  = abort;
            done_rx     = {receive_hshake, receive_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [26:0] out_vec();
        return {receive_hshake, receive_data, abort, byte_out, byte_valid, pid, data_len, done, status};
    endfunction

    task automatic add_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) tx_bits.push_back(b[i]);
    endtask

    function automatic logic [15:0] crc_over(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) c = {c[14:0], 1'b0} ^ ((c[15] ^ tx_bits[i]) ? 16'h8005 : 16'h0000);
        return c;
    endfunction

    // Appends the inverted CRC, high bit first, so the receiver residual is 0x800D
    task automatic add_crc();
        logic [15:0] c;
        c = crc_over(tx_bits.size());
        for (int i = 15; i >= 0; i--) tx_bits.push_back(~c[i]);
    endtask

    // Packet-level reference: outcome from PID rules, byte count, framing and CRC residual
    task automatic model(input bit dm, input logic [7:0] pidb, input int eerr_at,
                         output logic [2:0] es, output bit ea);
        int  n, nb, ev;
        bit  pid_ok;
        logic [7:0] b;
        n  = (eerr_at >= 0) ? eerr_at : tx_bits.size();
        nb = n / 8;
        ev = (nb > 2) ? nb - 2 : 0;
        es = 3'd0;
        ea = 1'b0;
        pid_ok = (pidb[7:4] == ~pidb[3:0]) &&
                 (dm ? (pidb[3:0] inside {4'h3, 4'hB}) : (pidb[3:0] inside {4'h2, 4'hA, 4'hE}));
        if (!pid_ok) begin
            es = 3'd5; ea = 1'b1; ev = 0;
        end else if (!dm) begin
            ev = 0;
            if (n > 0) begin es = 3'd7; ea = 1'b1; end
            else if (pidb[3:0] == 4'h2) es = 3'd0;
            else if (pidb[3:0] == 4'hA) es = 3'd1;
            else es = 3'd2;
        end else if (ev > MAXB) begin
            ev = MAXB; es = 3'd7; ea = 1'b1;
        end else if (eerr_at >= 0) begin
            es = 3'd7; ea = 1'b1;
        end else if ((n % 8 != 0) || (nb < 2)) begin
            es = 3'd7;
        end else begin
            es = (crc_over(n) == 16'h800D) ? 3'd3 : 3'd6;
        end
        exp_bytes.delete();
        for (int j = 0; j < ev; j++) begin
            for (int i = 0; i < 8; i++) b[i] = tx_bits[8 * j + i];
            exp_bytes.push_back(b);
        end
    endtask

    task automatic start_pkt(input bit dm, input int sync_delay);
        rx_bytes.delete();
        done_cnt     = 0;
        start_data   = dm;
        start_hshake = dm ? 1'($urandom_range(0, 1)) : 1'b1;
        tick();
        start_data   = 1'b0;
        start_hshake = 1'b0;
        repeat (sync_delay) tick();
        got_sync = 1'b1;
        tick();
        got_sync = 1'b0;
        check_eq("rx_enable", {receive_hshake, receive_data}, dm ? 2'b01 : 2'b10);
    endtask

    task automatic send_bit(input bit b, input bit with_eop);
        bit_valid = 1'b1; bit_in = b; eop = with_eop;
        tick();
        bit_valid = 1'b0; bit_in = 1'b0; eop = 1'b0;
        repeat ($urandom_range(0, 1)) tick();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && done_cnt == 0; i++) tick();
        check_eq("done_seen", 32'(done_cnt != 0), 32'd1);
        tick();
        tick();
        check_eq("done_once", done_cnt, 32'd1);
    endtask

    task automatic run_check(input bit dm, input int sync_delay, input logic [7:0] pidb,
                             input bit eop_last, input int eerr_at);
        logic [2:0] es;
        bit         ea;
        int         k;
        model(dm, pidb, eerr_at, es, ea);
        start_pkt(dm, sync_delay);
        for (int i = 0; i < 8; i++) send_bit(pidb[i], 1'b0);
        k = (eerr_at >= 0) ? eerr_at : tx_bits.size();
        for (int i = 0; i < k; i++) send_bit(tx_bits[i], eop_last && (eerr_at < 0) && (i == k - 1));
        if (eerr_at >= 0) begin
            eop_error = 1'b1; tick(); eop_error = 1'b0;
        end else if (!eop_last || k == 0) begin
            eop = 1'b1; tick(); eop = 1'b0;
        end
        wait_done();
        check_eq("status", done_status, es);
        check_eq("abort", done_abort, ea);
        check_eq("rx_off", done_rx, 2'b00);
        check_eq("pid", pid, pidb[3:0]);
        check_eq("data_len", data_len, exp_bytes.size());
        check_eq("n_bytes", rx_bytes.size(), exp_bytes.size());
        for (int j = 0; j < exp_bytes.size() && j < rx_bytes.size(); j++)
            check_eq("byte", rx_bytes[j], exp_bytes[j]);
    endtask

    initial begin
        int  cyc;
        bit  dm;
        int  kind, nb, pos;
        logic [7:0] pidb;
        logic [7:0] hs_pids[3];
        logic [7:0] d_pids[2];
        hs_pids = '{8'hD2, 8'h5A, 8'h1E};
        d_pids  = '{8'hC3, 8'h4B};

        rst = 1'b1; start_hshake = 1'b0; start_data = 1'b0; got_sync = 1'b0;
        eop_error = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; eop = 1'b0;
        repeat (2) tick();
        check_eq("reset_outputs", out_vec(), 27'd0);
        rst = 1'b0;
        tick();

        // Handshake ACK
        tx_bits.delete();
        run_check(1'b0, 3, 8'hD2, 1'b0, -1);
        check_eq("ack_code", done_status, 3'd0);

        // Timeout: done exactly TMO cycles after entering WAIT_SYNC
        done_cnt = 0;
        start_hshake = 1'b1;
        tick();
        start_hshake = 1'b0;
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            if (done === 1'b1) break;
            @(posedge clk);
            cyc++;
        end
        tick();
        check_eq("timeout_cycles", cyc, TMO);
        check_eq("timeout_status", done_status, 3'd4);
        check_eq("timeout_abort", done_abort, 1'b1);
        check_eq("timeout_rx_off", done_rx, 2'b00);
        check_eq("timeout_len", data_len, 7'd0);

        // Sync arriving on the last counted cycle wins over the timeout
        tx_bits.delete();
        run_check(1'b0, TMO - 1, 8'hD2, 1'b1, -1);
        check_eq("late_sync_status", done_status, 3'd0);

        // DATA0 good
        tx_bits.delete();
        add_byte(8'h01); add_byte(8'h02); add_byte(8'h03); add_crc();
        run_check(1'b1, 2, 8'hC3, 1'b1, -1);
        check_eq("data0_status", done_status, 3'd3);
        check_eq("data0_len", data_len, 7'd3);
        check_eq("data0_byte2", (rx_bytes.size() == 3) ? rx_bytes[2] : 8'hXX, 8'h03);

        // Bad CRC: one payload bit flipped
        tx_bits[9] = ~tx_bits[9];
        run_check(1'b1, 1, 8'hC3, 1'b0, -1);
        check_eq("badcrc_status", done_status, 3'd6);
        check_eq("badcrc_abort", done_abort, 1'b0);

        // Bad PID
        run_check(1'b1, 1, 8'hD3, 1'b0, -1);
        check_eq("badpid_status", done_status, 3'd5);

        // Framing: 21 data bits; eop_error mid-payload; handshake plus one extra bit
        tx_bits.delete();
        for (int i = 0; i < 21; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
        run_check(1'b1, 0, 8'hC3, 1'b0, -1);
        check_eq("frame21_status", done_status, 3'd7);
        tx_bits.delete();
        add_byte(8'hA5); add_byte(8'h5A); add_byte(8'h3C); add_crc();
        run_check(1'b1, 0, 8'hC3, 1'b0, 20);
        tx_bits.delete();
        tx_bits.push_back(1'b1);
        run_check(1'b0, 0, 8'hD2, 1'b0, -1);

        // Payload length boundary: exactly MAXB, then MAXB+1
        for (int p = MAXB; p <= MAXB + 1; p++) begin
            tx_bits.delete();
            for (int j = 0; j < p; j++) add_byte(8'($urandom));
            add_crc();
            run_check(1'b1, 1, 8'h4B, 1'b1, -1);
        end

        // Reset in the middle of RX_DATA
        tx_bits.delete();
        add_byte(8'h11); add_byte(8'h22); add_byte(8'h33); add_crc();
        start_pkt(1'b1, 2);
        for (int i = 0; i < 8; i++) send_bit(pidb_c3(i), 1'b0);
        for (int i = 0; i < 26; i++) send_bit(tx_bits[i], 1'b0);
        rst = 1'b1;
        #1;
        check_eq("midreset_outputs", out_vec(), 27'd0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("midreset_no_done", done_cnt, 32'd0);
        run_check(1'b1, 1, 8'hC3, 1'b0, -1);
        check_eq("after_reset_len", data_len, 7'd3);

        // Randomized packets
        for (int t = 0; t < 24; t++) begin
            tx_bits.delete();
            dm = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 5);
            if (dm) begin
                pidb = d_pids[$urandom_range(0, 1)];
                nb = $urandom_range(0, MAXB + 1);
                for (int j = 0; j < nb; j++) add_byte(8'($urandom));
                add_crc();
                if (kind == 0) begin
                    pos = $urandom_range(0, tx_bits.size() - 1);
                    tx_bits[pos] = ~tx_bits[pos];
                end else if (kind == 1) begin
                    repeat ($urandom_range(1, 7)) void'(tx_bits.pop_back());
                end
            end else begin
                pidb = hs_pids[$urandom_range(0, 2)];
                if (kind == 1) tx_bits.push_back(1'($urandom_range(0, 1)));
            end
            if (kind == 2) pidb = 8'($urandom);
            run_check(dm, $urandom_range(0, 10), pidb, 1'($urandom_range(0, 1)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    function automatic bit pidb_c3(input int i);
        logic [7:0] p;
        p = 8'hC3;
        return p[i];
    endfunction

endmodule

// File: doc/rc_packet_ctrl.md
Name: rc_packet_ctrl

Overview:
- Receive-side packet sequencer for the USB PHY chain (rc_dpdm → decode_nrzi → bit unstuffer).
- Arms the line receiver for either a handshake or a data packet, then times out the wait for SYNC.
- Assembles unstuffed bits LSB-first into bytes, validates the PID, and runs CRC16 over data payloads.
- Emits payload bytes plus a one-cycle completion with a result code to the protocol engine.

Parameters:
- TIMEOUT_CYCLES, 255: clk cycles to wait in WAIT_SYNC before declaring a timeout.
- MAX_BYTES, 64: maximum payload bytes, excluding PID and CRC.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start_hshake  in  1  pulse: receive a handshake packet
- start_data  in  1  pulse: receive a DATA0/DATA1 packet
- receive_hshake  out  1  level enable to rc_dpdm
- receive_data  out  1  level enable to rc_dpdm
- abort  out  1  one-cycle pulse to the datapath on timeout or early error
- got_sync  in  1  SYNC detected (from rc_dpdm)
- eop_error  in  1  malformed EOP (from rc_dpdm)
- bit_valid  in  1  unstuffed bit strobe
- bit_in  in  1  unstuffed bit, LSB-first on the wire
- eop  in  1  end of packet (end_unstuff)
- byte_out  out  8  payload byte
- byte_valid  out  1  byte_out qualifier, one cycle per byte
- pid  out  4  low nibble of the received PID; held until the next start
- data_len  out  7  payload bytes emitted; held until the next start
- done  out  1  one-cycle completion pulse
- status  out  3  result code; held until the next start

Behaviour:
- Reset value of every output is 0. Reset mid-packet returns the FSM to IDLE and clears the counters, buffers and CRC.
- Status codes: 0 ACK, 1 NAK, 2 STALL, 3 DATA_OK, 4 TIMEOUT, 5 PID_ERR, 6 CRC_ERR, 7 FRAME_ERR.
- States are IDLE → WAIT_SYNC → RX_PID → (RX_HS | RX_DATA) → FINISH → IDLE.
- IDLE:
  - start_data has priority over start_hshake.
  - A start clears pid, data_len, status, the bit counter and the hold buffer, and loads CRC = 16'hFFFF.
  - Starts are ignored outside IDLE.
- receive_hshake / receive_data are registered and asserted from the cycle after the start through the last RX cycle. Both are 0 in FINISH and IDLE.
- WAIT_SYNC:
  - Timeout counter increments each cycle.
  - got_sync → RX_PID.
  - Counter == TIMEOUT_CYCLES-1 without got_sync → FINISH, status TIMEOUT, abort.
  - If got_sync arrives in the same cycle as the final count, sync wins.
- Bit assembly:
  - On bit_valid, shift register = {bit_in, sr[7:1]} and the 3-bit counter increments.
  - A byte is complete when the counter wraps to 0.
- RX_PID, on byte complete:
  - Require PID[7:4] == ~PID[3:0].
  - Handshake mode accepts 0010/1010/1110 and goes to RX_HS.
  - Data mode accepts 0011/1011 and goes to RX_DATA.
  - Any other PID → FINISH, PID_ERR, abort.
- RX_HS:
  - eop with zero further bits → FINISH, status ACK/NAK/STALL from the PID.
  - Any bit_valid before eop → FINISH, FRAME_ERR, abort.
- RX_DATA:
  - Every bit_valid updates the serial CRC16 (poly 0x8005, reflected input order).
  - Completed bytes enter a 2-deep hold buffer.
  - When a third byte completes with the buffer full, the oldest byte is driven on byte_out with byte_valid the next cycle and data_len increments. The trailing 2 bytes (CRC) are therefore never emitted.
  - data_len would exceed MAX_BYTES → FINISH, FRAME_ERR, abort.
- EOP in RX_DATA is checked in this order:
  - bit counter ≠ 0 or hold count < 2 → FRAME_ERR;
  - else CRC residual ≠ 16'h800D → CRC_ERR;
  - else DATA_OK.
- If bit_valid and eop arrive in the same cycle, the bit is processed first and the EOP check includes it.
- eop_error in any RX state (including WAIT_SYNC) → FINISH, FRAME_ERR, abort. It takes precedence over all other events that cycle.
- eop in RX_PID → FINISH, FRAME_ERR, abort.
- FINISH lasts one cycle: done = 1 and status is valid. status, pid and data_len then hold until the next start. abort pulses in the same cycle as done when set.

Test Plan:
- Handshake ACK: start_hshake, got_sync after 3 cycles, bits of 8'hD2 LSB-first, eop → receive_hshake high throughout; done with status 0, pid 4'b0010, abort 0.
- Timeout (TIMEOUT_CYCLES = 16): start_hshake with no got_sync → done and abort in the same cycle, exactly 16 cycles after entering WAIT_SYNC; status 4. Repeat with got_sync on cycle 15 → no timeout.
- DATA0 good: PID 8'hC3, payload 8'h01, 8'h02, 8'h03, valid CRC16, eop → byte_valid three times with 01, 02, 03; data_len 3; status 3.
- Bad CRC: same packet with one payload bit flipped → bytes still emitted; status 6, no abort. Bad PID 8'hD3 → status 5, abort, receive_data drops.
- Framing: eop after 21 bits of data → status 7. eop_error during RX_DATA → status 7 plus abort. Handshake PID followed by one extra bit → status 7.
- Reset mid-RX_DATA: assert rst → all outputs 0 immediately; a following start_data packet is received cleanly with data_len counted from 0.
